// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   - ALUOp encodings driven by the decoder into ID/EX
//   - R-type function codes handled in EX
//   - mul/div FSM state enum and default iteration count
//   - neg_if(): conditional two's-complement helper for sign handling
package ex_pkg;

    localparam int DIV_ITERS_DEFAULT = 32;

    typedef logic [3:0] alu_op_t;
    typedef logic [5:0] func_t;

    localparam alu_op_t ALU_ADD   = 4'b0000;
    localparam alu_op_t ALU_SUB   = 4'b0001;
    localparam alu_op_t ALU_RTYPE = 4'b0010;
    localparam alu_op_t ALU_AND   = 4'b0011;
    localparam alu_op_t ALU_OR    = 4'b0100;
    localparam alu_op_t ALU_XOR   = 4'b0101;
    localparam alu_op_t ALU_SLT   = 4'b0110;
    localparam alu_op_t ALU_SLTU  = 4'b0111;

    localparam func_t F_SLL   = 6'h00;
    localparam func_t F_SRL   = 6'h02;
    localparam func_t F_SRA   = 6'h03;
    localparam func_t F_SLLV  = 6'h04;
    localparam func_t F_SRLV  = 6'h06;
    localparam func_t F_SRAV  = 6'h07;
    localparam func_t F_MFHI  = 6'h10;
    localparam func_t F_MTHI  = 6'h11;
    localparam func_t F_MFLO  = 6'h12;
    localparam func_t F_MTLO  = 6'h13;
    localparam func_t F_MULT  = 6'h18;
    localparam func_t F_MULTU = 6'h19;
    localparam func_t F_DIV   = 6'h1A;
    localparam func_t F_DIVU  = 6'h1B;
    localparam func_t F_ADD   = 6'h20;
    localparam func_t F_ADDU  = 6'h21;
    localparam func_t F_SUB   = 6'h22;
    localparam func_t F_SUBU  = 6'h23;
    localparam func_t F_AND   = 6'h24;
    localparam func_t F_OR    = 6'h25;
    localparam func_t F_XOR   = 6'h26;
    localparam func_t F_NOR   = 6'h27;
    localparam func_t F_SLT   = 6'h2A;
    localparam func_t F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX bundle into the execute stage and the EX results back out.
//   master: ID/EX register side (drives ex_*, observes results)
//   slave : ex_stage
//   ex_*       : registered control/data of the instruction currently in EX
//   alu_result, out_RegWrite, ov_flag : towards EX/MEM
//   stall_req  : to the hazard unit; hi_q/lo_q : HI/LO trace
interface ex_if;
    import ex_pkg::*;

    alu_op_t     ex_ALUOp;
    logic        ex_ALUSrc;
    logic [31:0] ex_rdata_a;
    logic [31:0] ex_rdata_b;
    logic [15:0] ex_imme_num;
    func_t       ex_func;
    logic [4:0]  ex_shamt;
    logic        ex_lui_sig;
    logic        ex_store_pc;
    logic [31:0] ex_next_instaddress;
    logic        ex_RegWrite;
    logic        ex_flush;
    logic        ex_stall_in;
    logic [31:0] alu_result;
    logic        out_RegWrite;
    logic        ov_flag;
    logic        stall_req;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    modport master (
        output ex_ALUOp, ex_ALUSrc, ex_rdata_a, ex_rdata_b, ex_imme_num, ex_func,
               ex_shamt, ex_lui_sig, ex_store_pc, ex_next_instaddress, ex_RegWrite,
               ex_flush, ex_stall_in,
        input  alu_result, out_RegWrite, ov_flag, stall_req, hi_q, lo_q
    );

    modport slave (
        input  ex_ALUOp, ex_ALUSrc, ex_rdata_a, ex_rdata_b, ex_imme_num, ex_func,
               ex_shamt, ex_lui_sig, ex_store_pc, ex_next_instaddress, ex_RegWrite,
               ex_flush, ex_stall_in,
        output alu_result, out_RegWrite, ov_flag, stall_req, hi_q, lo_q
    );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit with the architectural HI/LO.
//   clk, rst            : clock, async active-high reset
//   md_op               : MULT/MULTU/DIV/DIVU present in EX
//   md_div, md_signed   : divide vs multiply, signed vs unsigned
//   op_a, op_b          : Rs / Rt operands
//   mthi, mtlo          : move-to-HI/LO in EX (writes op_a)
//   flush, stall_in     : cancel instruction in EX / downstream hold
//   stall_req           : busy, hold IF/ID/EX
//   hi_q, lo_q          : HI/LO registers
// Macro EX_FAST_MUL_EN: multiplies take a single registered-multiplier cycle
// (IDLE->DONE) instead of the 32-step shift-add path; divides are unchanged.
module ex_muldiv import ex_pkg::*; #(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_op,
    input  logic        md_div,
    input  logic        md_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        flush,
    input  logic        stall_in,
    output logic        stall_req,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);
    localparam int CNT_W = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_ITERS - 1);

    md_state_e         state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    // mul: {partial product, remaining multiplier}; div: {remainder, quotient}
    logic [63:0]       acc;
    logic [31:0]       opnd;
    logic              neg_res, neg_rem, div_op, div0;
    logic              start, res_we, hi_we, lo_we, fast_mul;
    logic [31:0]       mag_a, mag_b, res_hi, res_lo;
    logic [32:0]       mul_sum, div_sh;
    logic [33:0]       div_diff;
    logic [63:0]       mul_step, div_step, prod_fix;

`ifdef EX_FAST_MUL_EN
    assign fast_mul = !md_div;
`else
    assign fast_mul = 1'b0;
`endif

    assign mag_a = neg_if(md_signed & op_a[31], op_a);
    assign mag_b = neg_if(md_signed & op_b[31], op_b);

    // shift-add: add multiplicand to the upper half when the multiplier LSB is set
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_step = {mul_sum, acc[31:1]};

    // restoring divide: shift next dividend bit into remainder, keep difference if non-negative
    assign div_sh   = {acc[63:32], acc[31]};
    assign div_diff = {1'b0, div_sh} - {2'b00, opnd};
    assign div_step = div_diff[33] ? {div_sh[31:0], acc[30:0], 1'b0}
                                   : {div_diff[31:0], acc[30:0], 1'b1};

    // sign fix-up; remainder already equals the dividend on divide-by-zero
    assign prod_fix = neg_res ? (64'd0 - acc) : acc;
    assign res_hi   = div_op ? neg_if(neg_rem, acc[63:32]) : prod_fix[63:32];
    assign res_lo   = div_op ? (div0 ? 32'hFFFF_FFFF : neg_if(neg_res, acc[31:0]))
                             : prod_fix[31:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (md_op && !flush) state_nxt = fast_mul ? MD_DONE : MD_BUSY;
            MD_BUSY: if (flush) state_nxt = MD_IDLE;
                     else if (cnt == LAST) state_nxt = MD_DONE;
            MD_DONE: if (flush || !stall_in) state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        start     = 1'b0;
        stall_req = 1'b0;
        res_we    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        case (state)
            MD_IDLE: begin
                start     = md_op && !flush;
                stall_req = start;
                hi_we     = mthi && !flush && !stall_in;
                lo_we     = mtlo && !flush && !stall_in;
            end
            MD_BUSY: stall_req = 1'b1;
            MD_DONE: res_we = !flush && !stall_in;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div_op  <= 1'b0;
            div0    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            if (start) begin
                cnt     <= '0;
                div_op  <= md_div;
                neg_res <= md_signed & (op_a[31] ^ op_b[31]);
                neg_rem <= md_signed & op_a[31];
                div0    <= (op_b == 32'd0);
                opnd    <= md_div ? mag_b : mag_a;
`ifdef EX_FAST_MUL_EN
                acc     <= md_div ? {32'd0, mag_a} : (64'(mag_a) * 64'(mag_b));
`else
                acc     <= {32'd0, md_div ? mag_a : mag_b};
`endif
            end else if (state == MD_BUSY) begin
                cnt <= cnt + CNT_W'(1);
                acc <= div_op ? div_step : mul_step;
            end
            if (res_we) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
            if (hi_we) hi_q <= op_a;
            if (lo_we) lo_q <= op_a;
        end
    end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage between ID/EX and EX/MEM.
//   clk, rst : clock, async active-high reset
//   bus      : ex_if.slave -- ex_* bundle in; alu_result, out_RegWrite,
//              ov_flag, stall_req, hi_q, lo_q out
// ALU/shifter/LUI/link path is combinational here; HI/LO and the iterative
// mul/div live in ex_muldiv (EX_FAST_MUL_EN selects its single-cycle multiplier).
module ex_stage import ex_pkg::*; #(
    parameter int DIV_ITERS = DIV_ITERS_DEFAULT
) (
    input logic clk,
    input logic rst,
    ex_if.slave bus
);
    logic [31:0] a, b, imm_ext, sum, diff, op_res;
    logic [4:0]  sh;
    logic        add_ov, sub_ov, slt, sltu, op_ov, no_wr, plain, rtype, md_op;

    assign a       = bus.ex_rdata_a;
    assign imm_ext = (bus.ex_ALUOp inside {ALU_AND, ALU_OR, ALU_XOR})
                   ? {16'd0, bus.ex_imme_num} : {{16{bus.ex_imme_num[15]}}, bus.ex_imme_num};
    assign b       = bus.ex_ALUSrc ? imm_ext : bus.ex_rdata_b;
    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ov  = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ov  = (a[31] != b[31]) && (diff[31] != a[31]);
    assign slt     = $signed(a) < $signed(b);
    assign sltu    = a < b;
    // func[2] distinguishes the variable shifts (SLLV/SRLV/SRAV) from shamt forms
    assign sh      = bus.ex_func[2] ? a[4:0] : bus.ex_shamt;

    // LUI and link override the ALU, so their ALUOp must not flag or suppress anything
    assign plain   = !bus.ex_lui_sig && !bus.ex_store_pc;
    assign rtype   = plain && (bus.ex_ALUOp == ALU_RTYPE);
    assign md_op   = rtype && (bus.ex_func inside {F_MULT, F_MULTU, F_DIV, F_DIVU});

    always_comb begin
        op_res = '0;
        op_ov  = 1'b0;
        no_wr  = 1'b0;
        case (bus.ex_ALUOp)
            ALU_ADD:  begin op_res = sum;  op_ov = add_ov; end
            ALU_SUB:  begin op_res = diff; op_ov = sub_ov; end
            ALU_AND:  op_res = a & b;
            ALU_OR:   op_res = a | b;
            ALU_XOR:  op_res = a ^ b;
            ALU_SLT:  op_res = {31'd0, slt};
            ALU_SLTU: op_res = {31'd0, sltu};
            ALU_RTYPE: begin
                case (bus.ex_func)
                    F_ADD:  begin op_res = sum;  op_ov = add_ov; end
                    F_ADDU: op_res = sum;
                    F_SUB:  begin op_res = diff; op_ov = sub_ov; end
                    F_SUBU: op_res = diff;
                    F_AND:  op_res = a & b;
                    F_OR:   op_res = a | b;
                    F_XOR:  op_res = a ^ b;
                    F_NOR:  op_res = ~(a | b);
                    F_SLT:  op_res = {31'd0, slt};
                    F_SLTU: op_res = {31'd0, sltu};
                    F_SLL, F_SLLV: op_res = bus.ex_rdata_b << sh;
                    F_SRL, F_SRLV: op_res = bus.ex_rdata_b >> sh;
                    F_SRA, F_SRAV: op_res = $signed(bus.ex_rdata_b) >>> sh;
                    F_MFHI: op_res = bus.hi_q;
                    F_MFLO: op_res = bus.lo_q;
                    F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: no_wr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.ov_flag      = op_ov && plain;
    assign bus.out_RegWrite = bus.ex_RegWrite && !bus.ov_flag && !(no_wr && plain);
    assign bus.alu_result   = bus.ex_lui_sig  ? {bus.ex_imme_num, 16'd0} :
                              bus.ex_store_pc ? bus.ex_next_instaddress + 32'd4 : op_res;

    // func[1]: divide; func[0]: unsigned
    ex_muldiv #(.DIV_ITERS(DIV_ITERS)) u_muldiv (
        .clk       (clk),
        .rst       (rst),
        .md_op     (md_op),
        .md_div    (bus.ex_func[1]),
        .md_signed (!bus.ex_func[0]),
        .op_a      (bus.ex_rdata_a),
        .op_b      (bus.ex_rdata_b),
        .mthi      (rtype && (bus.ex_func == F_MTHI)),
        .mtlo      (rtype && (bus.ex_func == F_MTLO)),
        .flush     (bus.ex_flush),
        .stall_in  (bus.ex_stall_in),
        .stall_req (bus.stall_req),
        .hi_q      (bus.hi_q),
        .lo_q      (bus.lo_q)
    );
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed bench for ex_stage; expected results are queued when an
// instruction is driven and popped when the result appears (ALU output or HI/LO write).
module tb_ex_stage;
    import ex_pkg::*;

`ifdef EX_FAST_MUL_EN
    localparam int MUL_STALL = 1;
`else
    localparam int MUL_STALL = 33;
`endif

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] m_hi, m_lo;

    always #5 clk = ~clk;

    ex_if bus();
    ex_stage #(.DIV_ITERS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $error("FAIL sb_empty: got %h expected queued entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic nop();
        bus.ex_ALUOp = ALU_ADD;   bus.ex_ALUSrc = 1'b0;
        bus.ex_rdata_a = '0;      bus.ex_rdata_b = '0;
        bus.ex_imme_num = '0;     bus.ex_func = '0;
        bus.ex_shamt = '0;        bus.ex_lui_sig = 1'b0;
        bus.ex_store_pc = 1'b0;   bus.ex_next_instaddress = '0;
        bus.ex_RegWrite = 1'b0;   bus.ex_flush = 1'b0;
    endtask

    task automatic drv(input alu_op_t op, input logic src, input logic [31:0] a,
                       input logic [31:0] b, input logic [15:0] imm, input func_t fn,
                       input logic [4:0] sh);
        nop();
        bus.ex_ALUOp = op;   bus.ex_ALUSrc = src;
        bus.ex_rdata_a = a;  bus.ex_rdata_b = b;
        bus.ex_imme_num = imm; bus.ex_func = fn;
        bus.ex_shamt = sh;   bus.ex_RegWrite = 1'b1;
    endtask

    task automatic alu(input string tag, input alu_op_t op, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                       input func_t fn, input logic [4:0] sh, input logic [31:0] e_res,
                       input logic e_ov, input logic e_rw);
        drv(op, src, a, b, imm, fn, sh);
        sb_push(tag, e_res);
        smp();
        sb_pop(bus.alu_result);
        chk({tag, "_ov"}, 32'(bus.ov_flag), 32'(e_ov));
        chk({tag, "_rw"}, 32'(bus.out_RegWrite), 32'(e_rw));
        step();
    endtask

    // Run one mul/div to completion, holding it in DONE for `hold` cycles via ex_stall_in.
    task automatic run_md(input string tag, input func_t fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi,
                          input logic [31:0] e_lo, input int e_stall, input int hold);
        int n;
        drv(ALU_RTYPE, 1'b0, a, b, 16'h0, fn, 5'd0);
        sb_push({tag, "_hi"}, e_hi);
        sb_push({tag, "_lo"}, e_lo);
        smp();
        chk({tag, "_rw"}, 32'(bus.out_RegWrite), 32'd0);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (bus.stall_req !== 1'b1) break;
            n++;
            step();
            smp();
        end
        chk({tag, "_stall_cycles"}, 32'(n), 32'(e_stall));
        if (hold > 0) begin
            bus.ex_stall_in = 1'b1;
            for (int k = 0; k < hold; k++) begin
                step();
                smp();
                chk({tag, "_held_hi"}, bus.hi_q, m_hi);
                chk({tag, "_held_lo"}, bus.lo_q, m_lo);
            end
            bus.ex_stall_in = 1'b0;
        end
        step();
        nop();
        smp();
        sb_pop(bus.hi_q);
        sb_pop(bus.lo_q);
        chk({tag, "_stall_after"}, 32'(bus.stall_req), 32'd0);
        m_hi = e_hi;
        m_lo = e_lo;
        step();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        bus.ex_stall_in = 1'b0;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_hi", bus.hi_q, 32'd0);
        chk("rst_lo", bus.lo_q, 32'd0);
        chk("rst_stall", 32'(bus.stall_req), 32'd0);
        step();
        rst = 1'b0;
        step();

        // ALU / overflow / immediate extension
        alu("add_ov",  ALU_ADD,  1'b0, 32'h7FFF_FFFF, 32'd1, 16'h0, 6'h0, 5'd0, 32'h8000_0000, 1'b1, 1'b0);
        alu("addi_sx", ALU_ADD,  1'b1, 32'd5, 32'h0, 16'hFFFF, 6'h0, 5'd0, 32'd4, 1'b0, 1'b1);
        alu("sub_ov",  ALU_SUB,  1'b0, 32'h8000_0000, 32'd1, 16'h0, 6'h0, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        alu("sub_neg", ALU_SUB,  1'b0, 32'd5, 32'd7, 16'h0, 6'h0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        alu("ori_zx",  ALU_OR,   1'b1, 32'h1234_0000, 32'h0, 16'h8001, 6'h0, 5'd0, 32'h1234_8001, 1'b0, 1'b1);
        alu("andi_zx", ALU_AND,  1'b1, 32'hFFFF_FFFF, 32'h0, 16'h8001, 6'h0, 5'd0, 32'h0000_8001, 1'b0, 1'b1);
        alu("xor",     ALU_XOR,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 16'h0, 6'h0, 5'd0, 32'h0FF0_0FF0, 1'b0, 1'b1);
        alu("slti",    ALU_SLT,  1'b1, 32'hFFFF_FFFF, 32'h0, 16'h0001, 6'h0, 5'd0, 32'd1, 1'b0, 1'b1);
        alu("sltu",    ALU_SLTU, 1'b0, 32'hFFFF_FFFF, 32'd1, 16'h0, 6'h0, 5'd0, 32'd0, 1'b0, 1'b1);
        alu("bad_op",  4'b1000,  1'b0, 32'd1, 32'd1, 16'h0, 6'h0, 5'd0, 32'd0, 1'b0, 1'b1);
        alu("r_addu",  ALU_RTYPE, 1'b0, 32'h7FFF_FFFF, 32'd1, 16'h0, F_ADDU, 5'd0, 32'h8000_0000, 1'b0, 1'b1);
        alu("r_add",   ALU_RTYPE, 1'b0, 32'h7FFF_FFFF, 32'd1, 16'h0, F_ADD, 5'd0, 32'h8000_0000, 1'b1, 1'b0);
        alu("r_nor",   ALU_RTYPE, 1'b0, 32'h0F0F_0000, 32'h0000_0F0F, 16'h0, F_NOR, 5'd0, 32'hF0F0_F0F0, 1'b0, 1'b1);
        alu("r_sra",   ALU_RTYPE, 1'b0, 32'h0, 32'h8000_0000, 16'h0, F_SRA, 5'd4, 32'hF800_0000, 1'b0, 1'b1);
        alu("r_srlv",  ALU_RTYPE, 1'b0, 32'h24, 32'h8000_0000, 16'h0, F_SRLV, 5'd0, 32'h0800_0000, 1'b0, 1'b1);
        alu("r_sllv",  ALU_RTYPE, 1'b0, 32'd1, 32'd3, 16'h0, F_SLLV, 5'd0, 32'd6, 1'b0, 1'b1);
        alu("r_slt",   ALU_RTYPE, 1'b0, 32'h8000_0000, 32'd0, 16'h0, F_SLT, 5'd0, 32'd1, 1'b0, 1'b1);

        // mul/div
        run_md("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
        alu("mfhi_div", ALU_RTYPE, 1'b0, 32'h0, 32'h0, 16'h0, F_MFHI, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        alu("mflo_div", ALU_RTYPE, 1'b0, 32'h0, 32'h0, 16'h0, F_MFLO, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b1);
        run_md("multu_ff", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_STALL, 0);
        run_md("mult_m3_5", F_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_STALL, 0);
        run_md("divu_by0", F_DIVU, 32'h1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 33, 0);
        run_md("div_min_m1", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 0);

        // flush at BUSY cycle 10: no write, stall drops on that edge
        drv(ALU_RTYPE, 1'b0, 32'd100, 32'd7, 16'h0, F_DIVU, 5'd0);
        step();
        for (int i = 1; i < 10; i++) step();
        nop();
        bus.ex_flush = 1'b1;
        smp();
        chk("flush_stall_busy", 32'(bus.stall_req), 32'd1);
        step();
        bus.ex_flush = 1'b0;
        smp();
        chk("flush_stall_drop", 32'(bus.stall_req), 32'd0);
        chk("flush_hi", bus.hi_q, m_hi);
        chk("flush_lo", bus.lo_q, m_lo);
        step();

        // MTHI/MTLO then MFHI/MFLO
        alu("mthi", ALU_RTYPE, 1'b0, 32'hCAFE_F00D, 32'h0, 16'h0, F_MTHI, 5'd0, 32'd0, 1'b0, 1'b0);
        alu("mfhi", ALU_RTYPE, 1'b0, 32'h0, 32'h0, 16'h0, F_MFHI, 5'd0, 32'hCAFE_F00D, 1'b0, 1'b1);
        alu("mtlo", ALU_RTYPE, 1'b0, 32'h1357_9BDF, 32'h0, 16'h0, F_MTLO, 5'd0, 32'd0, 1'b0, 1'b0);
        alu("mflo", ALU_RTYPE, 1'b0, 32'h0, 32'h0, 16'h0, F_MFLO, 5'd0, 32'h1357_9BDF, 1'b0, 1'b1);

        // reset while BUSY
        drv(ALU_RTYPE, 1'b0, 32'd100, 32'd7, 16'h0, F_DIVU, 5'd0);
        step();
        repeat (4) step();
        rst = 1'b1;
        nop();
        #1;
        chk("rstmid_hi", bus.hi_q, 32'd0);
        chk("rstmid_lo", bus.lo_q, 32'd0);
        chk("rstmid_stall", 32'(bus.stall_req), 32'd0);
        m_hi = '0;
        m_lo = '0;
        step();
        rst = 1'b0;
        step();

        // DONE held by ex_stall_in for 3 cycles
        run_md("div_hold", F_DIV, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2, 33, 3);
        alu("mflo_hold", ALU_RTYPE, 1'b0, 32'h0, 32'h0, 16'h0, F_MFLO, 5'd0, 32'hFFFF_FFF2, 1'b0, 1'b1);

        // LUI and link override the ALUOp path
        drv(ALU_ADD, 1'b1, 32'h0, 32'h0, 16'hABCD, 6'h0, 5'd0);
        bus.ex_lui_sig = 1'b1;
        sb_push("lui", 32'hABCD_0000);
        smp();
        sb_pop(bus.alu_result);
        step();
        drv(ALU_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 16'h0, 6'h0, 5'd0);
        bus.ex_store_pc = 1'b1;
        bus.ex_next_instaddress = 32'h100;
        sb_push("link", 32'h104);
        smp();
        sb_pop(bus.alu_result);
        chk("link_rw", 32'(bus.out_RegWrite), 32'd1);
        step();
        nop();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
